// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one load/store to the data cache,
// waits for its response and returns the aligned, extended load result.
module dmem_access_ctrl #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic             req_write,
   input  logic [2:0]       funct3,
   input  logic [width-1:0] addr,
   input  logic [width-1:0] wdata,
   input  logic [3:0]       wmask,
   output logic             dmem_read,
   output logic             dmem_write,
   output logic [width-1:0] dmem_address,
   output logic [width-1:0] dmem_wdata,
   output logic [3:0]       dmem_byte_enable,
   input  logic             dmem_resp,
   input  logic [width-1:0] dmem_rdata,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] load_data,
   output logic             misaligned
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        w_misalign;
   logic [1:0]  r_addr_lo;
   logic [2:0]  r_funct3;
   logic        r_write;

   // Only word and halfword accesses can be misaligned; undefined sizes never are.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic mis;
      mis = 1'b0;
      case (f3)
         3'b010:         mis = (a != 2'b00);
         3'b001, 3'b101: mis = a[0];
         default:        mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [width-1:0] align_load(input logic [2:0]       f3,
                                                   input logic [1:0]       a,
                                                   input logic [width-1:0] w);
      logic [7:0]       b;
      logic [15:0]      h;
      logic [width-1:0] res;
      case (a)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  res = {{(width-8){b[7]}}, b};
         3'b100:  res = {{(width-8){1'b0}}, b};
         3'b001:  res = {{(width-16){h[15]}}, h};
         3'b101:  res = {{(width-16){1'b0}}, h};
         default: res = w;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      w_misalign   = is_misaligned(funct3, addr[1:0]);
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_next_state = w_misalign ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            busy = 1'b1;
            if (dmem_resp) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Strobes, done and the captured request are registered so the cache sees
   // glitch-free, stable signals for the whole handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_lo        <= 2'b00;
         r_funct3         <= 3'b000;
         r_write          <= 1'b0;
         dmem_read        <= 1'b0;
         dmem_write       <= 1'b0;
         dmem_address     <= '0;
         dmem_wdata       <= '0;
         dmem_byte_enable <= 4'b0000;
         done             <= 1'b0;
         load_data        <= '0;
         misaligned       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_addr_lo        <= addr[1:0];
                  r_funct3         <= funct3;
                  r_write          <= req_write;
                  dmem_address     <= {addr[width-1:2], 2'b00};
                  dmem_wdata       <= wdata;
                  dmem_byte_enable <= req_write ? wmask : 4'b1111;
                  misaligned       <= w_misalign;
                  if (w_misalign) begin
                     done <= 1'b1;
                  end else begin
                     dmem_read  <= !req_write;
                     dmem_write <= req_write;
                  end
               end
            end
            ACCESS: begin
               if (dmem_resp) begin
                  dmem_read  <= 1'b0;
                  dmem_write <= 1'b0;
                  done       <= 1'b1;
                  if (!r_write) begin
                     load_data <= align_load(r_funct3, r_addr_lo, dmem_rdata);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller for the MEM stage. It sits directly downstream of the store-data shifter/byte-mask stage. It accepts one load or store per request, runs a read/write handshake with the data cache until the cache responds, and returns load data aligned and sign- or zero-extended per funct3. It also flags misaligned word and halfword accesses without issuing them to memory.

## Interface
Parameters:
- `width`, 32, data and address width (only 32 is supported).

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `rst_n`, in, 1, asynchronous, active-low reset.
- `req_valid`, in, 1, pipeline presents an access; held stable until `done`.
- `req_write`, in, 1, 1 = store, 0 = load.
- `funct3`, in, 3, access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `addr`, in, 32, byte address.
- `wdata`, in, 32, store data already shifted into byte lanes.
- `wmask`, in, 4, store byte mask, already lane-aligned.
- `dmem_read`, out, 1, cache read strobe.
- `dmem_write`, out, 1, cache write strobe.
- `dmem_address`, out, 32, word-aligned address ({addr[31:2],2'b00}).
- `dmem_wdata`, out, 32, registered `wdata`.
- `dmem_byte_enable`, out, 4, registered `wmask` for stores, 4'b1111 for reads.
- `dmem_resp`, in, 1, cache completion (one-cycle pulse).
- `dmem_rdata`, in, 32, cache read word, valid with `dmem_resp`.
- `busy`, out, 1, high whenever the state is not IDLE; the pipeline stalls on it.
- `done`, out, 1, one-cycle completion pulse.
- `load_data`, out, 32, aligned and extended load result, valid while `done` is high and held afterwards.
- `misaligned`, out, 1, valid with `done`; 1 means the access was rejected.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE, `req_valid` = 1:** register `addr`, `funct3`, `req_write`, `wdata` and `wmask`.
  - If the access is misaligned, go to DONE with `misaligned` = 1. No strobe is ever raised. Misaligned means: word (010) with addr[1:0] ≠ 0, or halfword (001/101) with addr[0] = 1.
  - Otherwise, go to ACCESS.
- **ACCESS:**
  - `dmem_read` = !req_write_q and `dmem_write` = req_write_q; the strobes are registered outputs held every cycle until `dmem_resp`.
  - On `dmem_resp`, capture the aligned `load_data` (loads only) and go to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then go to IDLE. `misaligned` and `load_data` hold until the next acceptance.
- **Load alignment:** select the byte by addr_q[1:0], or the halfword by addr_q[1], then extend:
  - 000 (b): sign-extend bit 7.
  - 100 (bu): zero-extend.
  - 001 (h): sign-extend bit 15.
  - 101 (hu): zero-extend.
  - 010 and any undefined funct3: full word.
- **Stores:** `load_data` is unchanged. Undefined store funct3 values use the mask as supplied.
- **Ignored inputs:**
  - `dmem_resp` outside ACCESS is ignored.
  - `req_valid` outside IDLE is ignored; the request is not re-accepted.
  - `req_valid` in the IDLE cycle that directly follows DONE is a new request.

## Timing
- **Reset (asynchronous assert, synchronous deassert release):**
  - State goes to IDLE.
  - `dmem_read`, `dmem_write`, `busy`, `done` and `misaligned` go to 0.
  - `dmem_address`, `dmem_wdata` and `load_data` go to 0; `dmem_byte_enable` goes to 0.
  - Reset during ACCESS abandons the transaction; a later `dmem_resp` is ignored.
- **Normal access:**
  - Request accepted at edge N.
  - Strobes are high from cycle N+1 until the edge where `dmem_resp` is sampled, at cycle M ≥ N+1.
  - Strobes are low and `done` is high in cycle M+1.
  - Minimum latency from acceptance to `done` is 2 cycles.
- **Misaligned access:** accepted at edge N; `done` and `misaligned` are high in cycle N+1.
- **Back-to-back:** the earliest next acceptance is the cycle after `done`. Sustained throughput is one access per 3 cycles.
- `busy` is high from the cycle after acceptance through the DONE cycle.

## Test plan
- **Load byte, sign-extended:** lb at addr 0x1003, `dmem_rdata` = 0x80AABBCC, resp 1 cycle after the strobe. Expect `load_data` = 0xFFFFFF80, `done` 2 cycles after acceptance, `dmem_address` = 0x1000.
- **Load halfword, zero-extended, slow cache:** lhu at 0x2002, resp after 5 wait cycles, rdata 0xBEEF1234. Expect `dmem_read` held for 5 cycles, `load_data` = 0x0000BEEF, one `done` pulse.
- **Store halfword:** sh at 0x3002, `wdata` = 0x56780000, `wmask` = 1100. Expect `dmem_write` = 1, `dmem_byte_enable` = 1100, `dmem_wdata` = 0x56780000, `dmem_read` = 0, `load_data` unchanged.
- **Misaligned word load:** lw at 0x4001. Expect no strobe at any cycle, `done` and `misaligned` = 1 in the next cycle. A following aligned lw clears `misaligned`.
- **Reset mid-access:** pull `rst_n` low during ACCESS, then raise `dmem_resp`. Expect all outputs 0 immediately, no `done`, and the next request to proceed normally.
- **Ignored inputs:** spurious `dmem_resp` in IDLE produces no state change. A new `req_valid` during ACCESS is not accepted until after `done`.
